div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 155 +++++++++++++++
 tb/tb_div_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Two-port round-robin front end for a shared iterative Divider; one request in flight.
// Define DIV_ARBITER_SIGNED_EN to compile in signed operand/result handling.
module div_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [W-1:0] req_dividend_0,
  input  logic [W-1:0] req_divisor_0,
  input  logic [W-1:0] req_dividend_1,
  input  logic [W-1:0] req_divisor_1,
  input  logic         req_signed_0,
  input  logic         req_signed_1,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [W-1:0] resp_quotient,
  output logic [W-1:0] resp_remainder,
  output logic         resp_div_by_zero,
  input  logic         resp_ready,
  output logic         div_launch,
  output logic [W-1:0] div_dividend,
  output logic [W-1:0] div_divisor,
  input  logic         div_busy,
  input  logic         div_by_zero,
  input  logic [W-1:0] div_quotient,
  input  logic [W-1:0] div_remainder
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         id_q, id_d;
  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rem_q, rem_d;
  logic         dbz_q, dbz_d;
  logic         grant;
  logic         accept;
  logic [W-1:0] fix_quo, fix_rem;

`ifdef DIV_ARBITER_SIGNED_EN
  logic sgn_q, sgn_d;
  logic dvd_neg, dvs_neg;

  // dvd_q/dvs_q keep the original operands; the Divider only ever sees magnitudes.
  assign dvd_neg      = sgn_q & dvd_q[W-1];
  assign dvs_neg      = sgn_q & dvs_q[W-1];
  assign div_dividend = dvd_neg ? -dvd_q : dvd_q;
  assign div_divisor  = dvs_neg ? -dvs_q : dvs_q;
  assign fix_quo      = (dvd_neg ^ dvs_neg) ? -div_quotient : div_quotient;
  assign fix_rem      = dvd_neg ? -div_remainder : div_remainder;

  always_comb begin
    sgn_d = sgn_q;
    if (accept) sgn_d = grant ? req_signed_1 : req_signed_0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sgn_q <= 1'b0;
    else       sgn_q <= sgn_d;
  end
`else
  logic unused_signed;

  assign unused_signed = req_signed_0 ^ req_signed_1;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign fix_quo       = div_quotient;
  assign fix_rem       = div_remainder;
`endif

  // On a tie the pointer decides; otherwise whichever single requester is valid.
  assign grant       = (req_valid_0 && req_valid_1) ? ptr_q : req_valid_1;
  assign req_ready_0 = (state_q == IDLE) && !reset && req_valid_0 && !grant;
  assign req_ready_1 = (state_q == IDLE) && !reset && req_valid_1 && grant;
  assign accept      = req_ready_0 | req_ready_1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = grant;
          dvd_d   = grant ? req_dividend_1 : req_dividend_0;
          dvs_d   = grant ? req_divisor_1  : req_divisor_0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (div_by_zero) begin
          quo_d   = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          state_d = RESP;
        end else if (!div_busy) begin
          quo_d   = fix_quo;
          rem_d   = fix_rem;
          dbz_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          ptr_d   = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign resp_valid       = (state_q == RESP);
  assign resp_id          = id_q;
  assign resp_quotient    = quo_q;
  assign resp_remainder   = rem_q;
  assign resp_div_by_zero = dbz_q;
  assign div_launch       = (state_q == LAUNCH);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter (W=8) with a small behavioural unsigned Divider model.
module tb_div_arbiter;
  localparam int unsigned W   = 8;
  localparam int          LAT = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [W-1:0] req_dividend_0, req_divisor_0, req_dividend_1, req_divisor_1;
  logic         req_signed_0, req_signed_1;
  logic         resp_valid, resp_id, resp_div_by_zero, resp_ready;
  logic [W-1:0] resp_quotient, resp_remainder;
  logic         div_launch, div_busy, div_by_zero;
  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;

  int total = 0;
  int bad   = 0;
  int launch_cnt = 0;

  div_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_dividend_0(req_dividend_0), .req_divisor_0(req_divisor_0),
    .req_dividend_1(req_dividend_1), .req_divisor_1(req_divisor_1),
    .req_signed_0(req_signed_0), .req_signed_1(req_signed_1),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_div_by_zero(resp_div_by_zero), .resp_ready(resp_ready),
    .div_launch(div_launch), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_by_zero(div_by_zero),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  // Divider model: busy from the launch edge; results only valid once busy drops.
  int           m_cnt;
  logic [W-1:0] m_pq, m_pr;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0; div_by_zero <= 1'b0; m_cnt <= 0;
      div_quotient <= '0; div_remainder <= '0; m_pq <= '0; m_pr <= '0;
    end else if (div_launch) begin
      div_quotient  <= 8'hA5;
      div_remainder <= 8'h5A;
      if (div_divisor == '0) begin
        div_by_zero <= 1'b1;
        div_busy    <= 1'b0;
      end else begin
        div_busy <= 1'b1;
        m_cnt    <= LAT - 1;
        m_pq     <= div_dividend / div_divisor;
        m_pr     <= div_dividend % div_divisor;
      end
    end else begin
      div_by_zero <= 1'b0;
      if (div_busy) begin
        if (m_cnt == 0) begin
          div_busy      <= 1'b0;
          div_quotient  <= m_pq;
          div_remainder <= m_pr;
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (!reset && div_launch) launch_cnt <= launch_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
    if (p == 0) begin
      req_valid_0 = v; req_dividend_0 = a; req_divisor_0 = b; req_signed_0 = s;
    end else begin
      req_valid_1 = v; req_dividend_1 = a; req_divisor_1 = b; req_signed_1 = s;
    end
  endtask

  task automatic accept(input string tag, input int p);
    int n = 0;
    #1;
    while (((p == 0) ? req_ready_0 : req_ready_1) !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_accept"}, 32'(n < 20), 1);
    @(posedge clk); #1;
    if (p == 0) req_valid_0 = 1'b0; else req_valid_1 = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic id, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic dbz, input int l0);
    int n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_resp_to"}, 32'(n < 40), 1);
    check({tag, "_id"}, resp_id, id);
    check({tag, "_quo"}, resp_quotient, q);
    check({tag, "_rem"}, resp_remainder, r);
    check({tag, "_dbz"}, resp_div_by_zero, dbz);
    check({tag, "_launches"}, launch_cnt - l0, 1);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
    int l0;
    l0 = launch_cnt;
    set_req(p, 1'b1, a, b, s);
    accept(tag, p);
    wait_resp(tag, p[0], q, r, dbz, l0);
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1;
    reset = 1'b1; resp_ready = 1'b0;
    set_req(0, 1'b1, 8'd1, 8'd1, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", req_ready_0, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_quo", resp_quotient, 0);
    check("rst_rem", resp_remainder, 0);
    check("rst_dbz", resp_div_by_zero, 0);
    check("rst_launch", div_launch, 0);
    check("rst_div_ops", {div_dividend, div_divisor}, 0);
    req_valid_0 = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Round robin: port 0 wins the first tie, then alternation.
    set_req(0, 1'b1, 8'd20, 8'd6, 1'b0);
    set_req(1, 1'b1, 8'd9, 8'd4, 1'b0);
    #1;
    check("rr_tie1_rdy0", req_ready_0, 1);
    check("rr_tie1_rdy1", req_ready_1, 0);
    l0 = launch_cnt; accept("rr0", 0); wait_resp("rr0", 1'b0, 8'd3, 8'd2, 1'b0, l0); ack();
    l0 = launch_cnt; accept("rr1", 1); wait_resp("rr1", 1'b1, 8'd2, 8'd1, 1'b0, l0); ack();
    set_req(0, 1'b1, 8'd100, 8'd10, 1'b0);
    set_req(1, 1'b1, 8'd50, 8'd7, 1'b0);
    #1;
    check("rr_tie2_rdy0", req_ready_0, 1);
    check("rr_tie2_rdy1", req_ready_1, 0);
    l0 = launch_cnt; accept("rr2", 0); wait_resp("rr2", 1'b0, 8'd10, 8'd0, 1'b0, l0); ack();
    l0 = launch_cnt; accept("rr3", 1); wait_resp("rr3", 1'b1, 8'd7, 8'd1, 1'b0, l0); ack();

    run("u7_3", 0, 8'd7, 8'd3, 1'b0, 8'd2, 8'd1, 1'b0);
    run("dbz5", 1, 8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1);
`ifdef DIV_ARBITER_SIGNED_EN
    run("s_m7_2", 0, 8'hF9, 8'd2, 1'b1, 8'hFD, 8'hFF, 1'b0);
    run("s_7_m2", 1, 8'd7, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
    run("s_ovf", 0, 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
    run("s_dbz", 1, 8'hFB, 8'd0, 1'b1, 8'hFF, 8'hFB, 1'b1);
`else
    run("nosign_f9_2", 0, 8'hF9, 8'd2, 1'b1, 8'h7C, 8'h01, 1'b0);
`endif

    // Stalled consumer: outputs hold, nothing accepted, no launch.
    l0 = launch_cnt;
    set_req(1, 1'b1, 8'd200, 8'd9, 1'b0);
    accept("stall", 1);
    wait_resp("stall", 1'b1, 8'd22, 8'd2, 1'b0, l0);
    set_req(0, 1'b1, 8'd1, 8'd1, 1'b0);
    set_req(1, 1'b1, 8'd1, 8'd1, 1'b0);
    l1 = launch_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", resp_valid, 1);
      check("stall_quo", resp_quotient, 22);
      check("stall_rem", resp_remainder, 2);
      check("stall_rdy", {req_ready_0, req_ready_1}, 0);
    end
    resp_ready = 1'b1;
    #1;
    check("stall_hs_rdy", {req_ready_0, req_ready_1}, 0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(posedge clk); #1;
    check("stall_no_launch", launch_cnt - l1, 0);
    check("stall_idle", resp_valid, 0);

    // Reset while the Divider is busy, then a clean request.
    set_req(0, 1'b1, 8'd100, 8'd7, 1'b0);
    accept("rstwait", 0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(1, 1'b1, 8'd3, 8'd1, 1'b0);
    #1;
    check("rstwait_rdy1", req_ready_1, 0);
    check("rstwait_valid", resp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid_1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rstwait_no_resp", resp_valid, 0);
    end
    run("after_rst", 0, 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
